// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder sequencer: FSM encoding and WIDTH bounds.
package serial_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full-adder cell built from two half adders; the only combinational
// path of the serial adder runs through here.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
    half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

    assign c_o = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two operands on start, adds them LSB-first
// one bit per clock through a single full-adder cell, then pulses done.
//
// state   | meaning
// IDLE    | waiting for start; sum/cout hold the last result
// RUN     | one operand bit per clock through the cell
// DONE    | done pulse, sum/cout valid; returns to IDLE next edge
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_add_ctrl: WIDTH out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_s;
    logic             cell_c;

    serial_fa_cell u_cell (
        .a_i (sha_q[0]),
        .b_i (shb_q[0]),
        .c_i (carry_q),
        .s_o (cell_s),
        .c_o (cell_c)
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sha_d   = a_i;
                    shb_d   = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                sum_d   = {cell_s, sum_q[WIDTH-1:1]};
                carry_d = cell_c;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit: counter is left at its terminal value rather than wrapping.
                    cout_d  = cell_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done_o = (state_q == ST_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] a_i = '0;
    logic [7:0] b_i = '0;
    logic       cin_i = 1'b0;
    logic       busy_o;
    logic       done_o;
    logic [7:0] sum_o;
    logic       cout_o;

    int total = 0;
    int bad = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: clean; mode 1: stray starts (AA/55) during RUN and DONE;
    // mode 2: operands scrambled every cycle after capture.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                          input int mode);
        int busy_cycles;
        busy_cycles = 0;
        a_i = a;
        b_i = b;
        cin_i = cin;
        start_i = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            step();
            if (busy_o) busy_cycles++;
            total++;
            if (done_o !== (i == 8)) begin
                bad++;
                $display("FAIL %s done i=%0d got=%b want=%b", name, i, done_o, (i == 8));
            end
            total++;
            if (busy_o !== (i <= 8)) begin
                bad++;
                $display("FAIL %s busy i=%0d got=%b want=%b", name, i, busy_o, (i <= 8));
            end
            if (i == 0) begin
                total++;
                if (sum_o !== 8'h00 || cout_o !== 1'b0) begin
                    bad++;
                    $display("FAIL %s clear_on_start got=%h/%b want=00/0", name, sum_o, cout_o);
                end
            end
            if (i >= 8) begin
                total++;
                if (sum_o !== exp_sum || cout_o !== exp_cout) begin
                    bad++;
                    $display("FAIL %s result i=%0d got=%h/%b want=%h/%b",
                             name, i, sum_o, cout_o, exp_sum, exp_cout);
                end
            end
            start_i = (mode == 1) && (i == 3 || i == 8);
            if (start_i) begin
                a_i = 8'hAA;
                b_i = 8'h55;
            end
            if (mode == 2) begin
                a_i = 8'($urandom);
                b_i = 8'($urandom);
                cin_i = 1'($urandom);
            end
        end
        total++;
        if (busy_cycles != 9) begin
            bad++;
            $display("FAIL %s busy_len got=%0d want=9", name, busy_cycles);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || sum_o !== 8'h00 || cout_o !== 1'b0) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
                     busy_o, done_o, sum_o, cout_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        step();
        total++;
        if (sum_o !== 8'hFF || cout_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_idle got=%h/%b want=ff/1", sum_o, cout_o);
        end
    endtask

    task automatic test_ignored_start();
        run_op("ignore_start", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL no_queue i=%0d got done=%b busy=%b want 0/0", i, done_o, busy_o);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        a_i = 8'hF0;
        b_i = 8'h0F;
        cin_i = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        #2 rst_i = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || sum_o !== 8'h00 || cout_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
                     busy_o, done_o, sum_o, cout_o);
        end
        step();
        rst_i = 1'b0;
        step();
        run_op("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        a_i = 8'h80;
        b_i = 8'h80;
        cin_i = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done_o) dones++;
            total++;
            if (done_o !== ((i % 10) == 8)) begin
                bad++;
                $display("FAIL b2b_done i=%0d got=%b want=%b", i, done_o, ((i % 10) == 8));
            end
            if ((i % 10) == 8) begin
                total++;
                if (sum_o !== 8'h00 || cout_o !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_result i=%0d got=%h/%b want=00/1", i, sum_o, cout_o);
                end
            end
        end
        start_i = 1'b0;
        total++;
        if (dones != 3) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=3", dones);
        end
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_operand_change();
        run_op("scramble", 8'hC3, 8'h4E, 1'b1, 8'h12, 1'b1, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_operand_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer. It accepts two WIDTH-bit operands and a carry-in on a start pulse, then steps them LSB-first through one full-adder cell, one bit per clock. The cell is built from two HalfAdder instances. The controller owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake. It is the area-minimal alternative to the parallel ripple adders in this library.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset; clears all state immediately.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on accepted Start.
- B  input  WIDTH  operand B; captured on accepted Start.
- Cin  input  1  carry-in; captured on accepted Start.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse; Sum/Cout valid.
- Sum  output  WIDTH  result register; holds last result until next accepted Start.
- Cout  output  1  final carry; held with Sum.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, Start=1: load ShA<=A, ShB<=B, carry<=Cin, cnt<=0, Sum<=0, Cout<=0; go to RUN.
- IDLE, Start=0: hold all registers.
- RUN, each edge:
  - The cell computes s = ShA[0]^ShB[0]^carry and c = majority(ShA[0], ShB[0], carry).
  - ShA and ShB shift right by 1.
  - Sum shifts right with s entering at bit WIDTH-1; carry<=c; cnt<=cnt+1.
- RUN, cnt==WIDTH-1: final bit as above; Cout<=c; go to DONE.
- DONE: Done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Start in RUN or DONE is ignored: no queueing, no error flag.
- Start held high continuously starts a new operation on every IDLE cycle.
- Counter width is $clog2(WIDTH). cnt never wraps within one operation.
- Rst asserted at any time, including mid-RUN: state=IDLE and all of Sum, Cout, Done, Busy, ShA, ShB, carry, cnt =0 immediately. The in-flight result is discarded.
- Reset values: Busy=0, Done=0, Sum=0, Cout=0.
- A, B and Cin may change freely after the accepting edge without affecting the result.

## Timing
- Start accepted at edge k.
- RUN occupies edges k+1 .. k+WIDTH.
- Done is high between edges k+WIDTH and k+WIDTH+1; the block is back in IDLE after edge k+WIDTH+1.
- Latency: WIDTH cycles from the accepting edge to Done.
- Throughput: one operation per WIDTH+2 cycles with Start held high.
- Busy rises the cycle after the accepting edge and falls with Done.
- The only combinational path is through the single full-adder cell, including the HalfAdder gate delays (2 HA levels plus OR). It must settle within one Clk period.

## Structure
- Shared package serial_add_pkg:
  - 2-bit state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
  - WIDTH legality bounds.
- One sub-module: serial_fa_cell, made of two HalfAdder instances plus an OR for carry. It is instantiated once.
- The FSM, shift registers, counter and carry flop stay in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=8.
- A=8'h5A, B=8'h3C, Cin=0, Start pulse -> Done exactly 8 cycles later; Sum=8'h96, Cout=0; Busy high for 9 cycles.
- A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Cout=1. A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
- Start in progress with A=8'h10, B=8'h01; pulse Start with A=8'hAA, B=8'h55 on cycles 3 and 8 (during RUN and DONE) -> both ignored; result Sum=8'h11, Cout=0; next Done only after a fresh Start in IDLE.
- Rst asserted mid-RUN (cycle 4) -> same cycle Busy=0, Done=0, Sum=0, Cout=0. After release, Start with A=8'h01, B=8'h02 -> Sum=8'h03 on time.
- Start held high for 30 cycles with A=8'h80, B=8'h80, Cin=0 -> Done pulses every 10 cycles; each result is Sum=8'h00, Cout=1.
- Operands changed every cycle during RUN -> result equals the operands captured at the accepting edge.
